// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops load the output registers on accept; MUL/DIVU iterate STEP bits per edge.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] excess,
  output logic             zero,
  output logic             parity,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal
);

  localparam int ITER = WIDTH / STEP;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0]    ITER_C = CW'(ITER);
  localparam logic [WIDTH-1:0] W_VAL  = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_AND = 4'd3,
                         OP_OR  = 4'd4, OP_XOR = 4'd5, OP_SHF = 4'd6, OP_ROT = 4'd7,
                         OP_ADC = 4'd8, OP_DIV = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;   // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opa_q, opa_d;     // MUL multiplicand or DIV divisor
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d, excess_q, excess_d;
  logic               zero_q, zero_d, parity_q, parity_d, negative_q, negative_d;
  logic               carry_q, carry_d, overflow_q, overflow_d;
  logic               div_zero_q, div_zero_d, illegal_q, illegal_d;
  logic               cin_q, cin_d;

  // Single-cycle datapath
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag, shamt, rot;
  logic [2*WIDTH-1:0] shl, shr, rotl, rotr;
  logic [WIDTH-1:0]   sc_res, sc_exc;
  logic               sc_carry, sc_ovf, sc_ill;

  assign mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign shamt = (mag >= W_VAL) ? W_VAL : mag;
  assign rot   = mag % W_VAL;
  assign shl   = {{WIDTH{1'b0}}, a} << shamt;
  assign shr   = {a, {WIDTH{1'b0}}} >> shamt;
  assign rotl  = {a, a} << rot;
  assign rotr  = {a, a} >> rot;

  always_comb begin
    sum      = '0;
    sc_res   = '0;
    sc_exc   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC: begin
        if (op == OP_SUB) sum = {1'b0, a} - {1'b0, b};
        else if (op == OP_ADD) sum = {1'b0, a} + {1'b0, b};
        else sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_q};
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_exc   = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
        if (op == OP_SUB)
          sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else
          sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_SHF: begin
        if (b[WIDTH-1]) begin
          sc_res = shr[2*WIDTH-1:WIDTH];
          sc_exc = shr[WIDTH-1:0];
        end else begin
          sc_res = shl[WIDTH-1:0];
          sc_exc = shl[2*WIDTH-1:WIDTH];
        end
        sc_carry = |sc_exc;
      end
      OP_ROT: sc_res = b[WIDTH-1] ? rotr[WIDTH-1:0] : rotl[2*WIDTH-1:WIDTH];
      OP_MUL, OP_DIV: ;
      default: sc_ill = 1'b1;
    endcase
  end

  // Multiply: retire STEP multiplier bits per edge into the high half
  logic [WIDTH+STEP-1:0] mul_upper;
  logic [2*WIDTH-1:0]    mul_next;

  assign mul_upper = {{STEP{1'b0}}, work_q[2*WIDTH-1:WIDTH]}
                   + ({{STEP{1'b0}}, opa_q} * {{WIDTH{1'b0}}, work_q[STEP-1:0]});

  generate
    if (STEP < WIDTH) begin : g_mul_narrow
      assign mul_next = {mul_upper, work_q[WIDTH-1:STEP]};
    end else begin : g_mul_full
      assign mul_next = mul_upper;
    end
  endgenerate

  // Divide: STEP chained restoring stages; b==0 naturally yields all-ones and remainder a
  logic [WIDTH-1:0]   rem_s [STEP+1];
  logic [WIDTH-1:0]   quo_s [STEP+1];
  logic [2*WIDTH-1:0] div_next;

  assign rem_s[0] = work_q[2*WIDTH-1:WIDTH];
  assign quo_s[0] = work_q[WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_div
      logic [WIDTH:0]   trial;
      logic [WIDTH-1:0] diff;
      logic             ge;
      assign trial        = {rem_s[gi], quo_s[gi][WIDTH-1]};
      assign ge           = trial >= {1'b0, opa_q};
      assign diff         = trial[WIDTH-1:0] - opa_q;
      assign rem_s[gi+1]  = ge ? diff : trial[WIDTH-1:0];
      assign quo_s[gi+1]  = {quo_s[gi][WIDTH-2:0], ge};
    end
  endgenerate

  assign div_next = {rem_s[STEP], quo_s[STEP]};

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    opa_d       = opa_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    excess_d    = excess_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    cin_d       = cin_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          cnt_d = '0;
          if (op == OP_MUL) begin
            state_d = S_MUL;
            opa_d   = a;
            work_d  = {{WIDTH{1'b0}}, b};
          end else if (op == OP_DIV) begin
            state_d = S_DIV;
            opa_d   = b;
            work_d  = {{WIDTH{1'b0}}, a};
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_res;
            excess_d    = sc_exc;
            carry_d     = sc_carry;
            overflow_d  = sc_ovf;
            div_zero_d  = 1'b0;
            illegal_d   = sc_ill;
            if (op == OP_ADD || op == OP_SUB || op == OP_ADC) cin_d = sc_carry;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == ITER_C) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          result_d    = work_q[WIDTH-1:0];
          excess_d    = work_q[2*WIDTH-1:WIDTH];
          carry_d     = (state_q == S_MUL) && (|work_q[2*WIDTH-1:WIDTH]);
          overflow_d  = 1'b0;
          div_zero_d  = (state_q == S_DIV) && (opa_q == '0);
          illegal_d   = 1'b0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          work_d = (state_q == S_MUL) ? mul_next : div_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zero_d     = (result_d == '0);
    parity_d   = result_d[0];
    negative_d = result_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      opa_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      excess_q    <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      cin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      opa_q       <= opa_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      excess_q    <= excess_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
      cin_q       <= cin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign excess    = excess_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;

endmodule
